// File: rtl/jtag_pkg.sv
// ----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG command sequencer and its shift engine:
//   - engine shift widths (instruction width, FIFO word width, DR byte count)
//   - sequencer state encoding
//   - packet header codes (header byte bits [7:6])
//   - error codes reported on err_code
// ----------------------------------------------------------------------------
package jtag_pkg;

    // Engine shift widths; the engine shifts JTAG_FIFO_WIDTH*JTAG_DR_BYTES DR bits.
    localparam int JTAG_IR_WIDTH   = 6;
    localparam int JTAG_FIFO_WIDTH = 8;
    localparam int JTAG_DR_BYTES   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_KICK      = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5
    } seq_state_e;

    // Header byte bits [7:6]; any code with the top bit set is a bad header.
    typedef enum logic [1:0] {
        HDR_IR = 2'b00,
        HDR_DR = 2'b01
    } hdr_code_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_HDR     = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_e;

endpackage

// File: rtl/jtag_cmd_seq_wdog.sv
// ----------------------------------------------------------------------------
// jtag_cmd_seq_wdog
// Wait-state watchdog for the command sequencer. Counts clk cycles while the
// sequencer sits in one of its engine-wait states; the count restarts from
// zero on every state entry.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   i_run      in   sequencer is in a wait state
//   i_clear    in   sequencer changes state this cycle (count restarts)
//   o_expired  out  this is cycle TIMEOUT_CYCLES of the current wait state
//
// Only instantiated when JTAG_CMD_SEQ_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module jtag_cmd_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen on the last allowed cycle: the first cycle in a state reads 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Depends only on the register and i_run, so the sequencer may feed its
    // next-state decision back into i_clear without forming a loop.
    assign o_expired = i_run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/jtag_cmd_seq.sv
// ----------------------------------------------------------------------------
// jtag_cmd_seq
// Host-side command sequencer for the JTAG shift engine. Parses a host byte
// stream into IR/DR packets, writes payloads into the engine's instruction or
// data FIFO, kicks the engine with a one-cycle work pulse (op held stable),
// waits for a full busy rise/fall and reports done / err.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_data/s_ready   host byte stream (s_ready combinational)
//   op, work                 engine control: op 1=data 0=instruction, start pulse
//   busy                     engine busy
//   wr_instruction, wdata_instruction, full_instruction   instruction FIFO
//   wr_data, wdata_data, full_data                        data FIFO
//   done                     one-cycle pulse when a packet completes
//   err, err_code            one-cycle error pulse, code held until next err
//
// Header byte bits [7:6]: 00 IR (1 payload byte), 01 DR (DR_BYTES payload
// bytes), 1x bad header. Bits [5:0] are ignored.
//
// Build option: define JTAG_CMD_SEQ_TIMEOUT_EN to add a wait-state watchdog
// (TIMEOUT_CYCLES) that aborts the packet with err_code=10.
// ----------------------------------------------------------------------------
module jtag_cmd_seq
    import jtag_pkg::*;
#(
    parameter int DATA_INSTRUCTION = JTAG_IR_WIDTH,
    parameter int DATA_FIFO        = JTAG_FIFO_WIDTH,
    parameter int DR_BYTES         = JTAG_DR_BYTES,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [DATA_FIFO-1:0]        s_data,
    output logic                        s_ready,
    output logic                        op,
    output logic                        work,
    input  logic                        busy,
    output logic                        wr_instruction,
    output logic [DATA_INSTRUCTION-1:0] wdata_instruction,
    input  logic                        full_instruction,
    output logic                        wr_data,
    output logic [DATA_FIFO-1:0]        wdata_data,
    input  logic                        full_data,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code
);

    if (TIMEOUT_CYCLES < 1 || DR_BYTES < 1 || DATA_FIFO < 2 ||
        DATA_INSTRUCTION > DATA_FIFO) begin : g_bad_params
        $error("jtag_cmd_seq: illegal parameter combination");
    end

    localparam int CNT_W = $clog2(DR_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_IR = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DR = CNT_W'(DR_BYTES);

    seq_state_e                  r_state;
    seq_state_e                  w_state_next;
    logic                        r_op;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_work;
    logic                        r_wr_instruction;
    logic                        r_wr_data;
    logic [DATA_INSTRUCTION-1:0] r_wdata_instruction;
    logic [DATA_FIFO-1:0]        r_wdata_data;
    logic                        r_done;
    logic                        r_err;
    logic [1:0]                  r_err_code;

    logic       w_s_ready;
    logic       w_target_full;
    logic       w_wr_pend;
    logic [1:0] w_hdr_code;
    logic       w_hdr_hs;
    logic       w_hdr_bad;
    logic       w_hdr_good_hs;
    logic       w_hdr_bad_hs;
    logic       w_pay_hs;
    logic       w_last_wr;
    logic       w_timeout;
    logic       w_timeout_fire;
    logic       w_done_set;

    // ------------------------------------------------------------------
    // Host handshake
    // ------------------------------------------------------------------
    assign w_target_full = r_op ? full_data : full_instruction;
    // A write strobe in flight blocks the next byte: one byte per 2 cycles.
    assign w_wr_pend     = r_wr_instruction | r_wr_data;

    assign w_s_ready = !rst &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_LOAD) && !w_target_full && !w_wr_pend));

    assign w_hdr_code    = s_data[DATA_FIFO-1 -: 2];
    assign w_hdr_bad     = (w_hdr_code != HDR_IR) && (w_hdr_code != HDR_DR);
    assign w_hdr_hs      = s_valid && w_s_ready && (r_state == ST_IDLE);
    assign w_hdr_good_hs = w_hdr_hs && !w_hdr_bad;
    assign w_hdr_bad_hs  = w_hdr_hs && w_hdr_bad;
    assign w_pay_hs      = s_valid && w_s_ready && (r_state == ST_LOAD);

    // The counter already holds the packet length when the final strobe is out.
    assign w_last_wr = w_wr_pend && (r_cnt == (r_op ? CNT_DR : CNT_IR));

    // ------------------------------------------------------------------
    // Optional wait-state watchdog
    // ------------------------------------------------------------------
`ifdef JTAG_CMD_SEQ_TIMEOUT_EN
    logic w_wd_run;
    logic w_wd_clear;

    assign w_wd_run   = (r_state == ST_WAIT_IDLE) || (r_state == ST_WAIT_BUSY) ||
                        (r_state == ST_WAIT_DONE);
    assign w_wd_clear = (w_state_next != r_state);

    jtag_cmd_seq_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_wd_run),
        .i_clear   (w_wd_clear),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // In the wait states the awaited busy level wins over a same-cycle timeout.
    always_comb begin
        w_state_next   = r_state;
        w_done_set     = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_good_hs) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_wr) begin
                    w_state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!busy) begin
                    w_state_next = ST_KICK;
                end else if (w_timeout) begin
                    w_state_next   = ST_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_KICK: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_next   = ST_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end else if (w_timeout) begin
                    w_state_next   = ST_IDLE;
                    w_timeout_fire = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and packet context
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op                <= 1'b0;
            r_cnt               <= '0;
            r_work              <= 1'b0;
            r_wr_instruction    <= 1'b0;
            r_wr_data           <= 1'b0;
            r_wdata_instruction <= '0;
            r_wdata_data        <= '0;
            r_done              <= 1'b0;
            r_err               <= 1'b0;
            r_err_code          <= ERR_NONE;
        end else begin
            // work is high exactly in the ST_KICK cycle.
            r_work <= (w_state_next == ST_KICK);
            r_done <= w_done_set;
            r_err  <= w_hdr_bad_hs || w_timeout_fire;

            if (w_hdr_bad_hs) begin
                r_err_code <= ERR_HDR;
            end else if (w_timeout_fire) begin
                r_err_code <= ERR_TIMEOUT;
            end

            // op stays put until the next good header, so it is stable
            // through the whole engine transaction.
            if (w_hdr_good_hs) begin
                r_op  <= (w_hdr_code == HDR_DR);
                r_cnt <= '0;
            end else if (w_pay_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_wr_instruction <= w_pay_hs && !r_op;
            r_wr_data        <= w_pay_hs && r_op;

            if (w_pay_hs && !r_op) begin
                r_wdata_instruction <= s_data[DATA_INSTRUCTION-1:0];
            end
            if (w_pay_hs && r_op) begin
                r_wdata_data <= s_data;
            end
        end
    end

    assign s_ready           = w_s_ready;
    assign op                = r_op;
    assign work              = r_work;
    assign wr_instruction    = r_wr_instruction;
    assign wdata_instruction = r_wdata_instruction;
    assign wr_data           = r_wr_data;
    assign wdata_data        = r_wdata_data;
    assign done              = r_done;
    assign err               = r_err;
    assign err_code          = r_err_code;

endmodule

// File: tb/tb_jtag_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_jtag_cmd_seq
// Self-checking bench for jtag_cmd_seq: a table of packets with hand-computed
// expected FIFO writes / op / done / err, plus hand-written sequences for
// reset, engine-busy-at-startup, backpressure, mid-packet reset and the
// wait-state watchdog (JTAG_CMD_SEQ_TIMEOUT_EN) or its absence.
// ----------------------------------------------------------------------------
module tb_jtag_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       op;
    logic       work;
    logic       busy;
    logic       wr_instruction;
    logic [5:0] wdata_instruction;
    logic       full_instruction;
    logic       wr_data;
    logic [7:0] wdata_data;
    logic       full_data;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    jtag_cmd_seq #(
        .DATA_INSTRUCTION (6),
        .DATA_FIFO        (8),
        .DR_BYTES         (4),
        .TIMEOUT_CYCLES   (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .op                (op),
        .work              (work),
        .busy              (busy),
        .wr_instruction    (wr_instruction),
        .wdata_instruction (wdata_instruction),
        .full_instruction  (full_instruction),
        .wr_data           (wr_data),
        .wdata_data        (wdata_data),
        .full_data         (full_data),
        .done              (done),
        .err               (err),
        .err_code          (err_code)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ------------------------------------------------------------------
    // Monitor: records FIFO writes and pulse events at the falling edge
    // ------------------------------------------------------------------
    logic [7:0] mon_ir[$];
    logic [7:0] mon_dr[$];
    int         mon_cyc  = 0;
    int         mon_work = 0;
    int         mon_done = 0;
    int         mon_err  = 0;
    int         work_cyc = 0;
    int         err_cyc  = 0;
    logic [1:0] mon_code = 2'b00;
    logic       op_at_work = 1'b0;
    logic       op_at_done = 1'b0;

    always @(negedge clk) begin
        mon_cyc++;
        if (wr_instruction) mon_ir.push_back({2'b00, wdata_instruction});
        if (wr_data)        mon_dr.push_back(wdata_data);
        if (work) begin
            mon_work++;
            work_cyc   = mon_cyc;
            op_at_work = op;
        end
        if (done) begin
            mon_done++;
            op_at_done = op;
        end
        if (err) begin
            mon_err++;
            err_cyc  = mon_cyc;
            mon_code = err_code;
        end
    end

    // ------------------------------------------------------------------
    // Engine busy model: rises 1 cycle after work, stays high 40 cycles.
    // force_busy holds it high; never_rise makes the engine ignore work.
    // ------------------------------------------------------------------
    logic force_busy = 1'b0;
    logic never_rise = 1'b0;

    initial begin
        int  left;
        bit  pend;
        left = 0;
        pend = 1'b0;
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pend) begin
                pend = 1'b0;
                left = 40;
            end
            if (work && !never_rise) pend = 1'b1;
            busy = force_busy || (left > 0);
            if (left > 0) left--;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                $display("byte 0x%02h accepted", b);
                return;
            end
        end
        s_valid = 1'b0;
        bound_expired("send_byte");
    endtask

    task automatic wait_end(input int bd, input int be, input string name);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (mon_done > bd || mon_err > be) return;
        end
        bound_expired({name, "_end"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_work"}, 32'(work), 32'd0);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_wr_ins"}, 32'(wr_instruction), 32'd0);
        check({tag, "_wr_dat"}, 32'(wr_data), 32'd0);
        check({tag, "_wdata_ins"}, 32'(wdata_instruction), 32'd0);
        check({tag, "_wdata_dat"}, 32'(wdata_data), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Packet table
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [7:0] hdr;
        int         npay;
        logic [7:0] pay[4];
        bit         exp_err;
        logic       exp_op;
        int         exp_nir;
        int         exp_ndr;
        logic [7:0] exp_wr[4];
    } vec_t;

    localparam int NVEC = 7;
    vec_t vt[NVEC];

    task automatic set_vec(input int i, input string name, input logic [7:0] hdr, input int npay,
                           input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3, input bit e_err, input logic e_op,
                           input int e_nir, input int e_ndr, input logic [7:0] w0,
                           input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
        vt[i].name = name;    vt[i].hdr = hdr;      vt[i].npay = npay;
        vt[i].pay[0] = p0;    vt[i].pay[1] = p1;    vt[i].pay[2] = p2;    vt[i].pay[3] = p3;
        vt[i].exp_err = e_err; vt[i].exp_op = e_op;
        vt[i].exp_nir = e_nir; vt[i].exp_ndr = e_ndr;
        vt[i].exp_wr[0] = w0; vt[i].exp_wr[1] = w1; vt[i].exp_wr[2] = w2; vt[i].exp_wr[3] = w3;
    endtask

    initial begin
        int bi, bdr, bw, bdn, be, low, nw;

        //       idx name               hdr    n  payload                     err op  nir ndr expected writes
        set_vec(0, "ir_2a",           8'h00, 1, 8'h2A, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h2A, 8'h00, 8'h00, 8'h00);
        set_vec(1, "dr_deadbeef",     8'h40, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 1, 0, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        set_vec(2, "bad_hdr_c0",      8'hC0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        set_vec(3, "ir_05_after_bad", 8'h00, 1, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h05, 8'h00, 8'h00, 8'h00);
        set_vec(4, "ir_hdr3f_payff",  8'h3F, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h3F, 8'h00, 8'h00, 8'h00);
        set_vec(5, "dr_hdr7f",        8'h7F, 4, 8'h01, 8'h02, 8'h03, 8'h80, 0, 1, 0, 4, 8'h01, 8'h02, 8'h03, 8'h80);
        set_vec(6, "bad_hdr_80",      8'h80, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);

        s_valid          = 1'b0;
        s_data           = 8'h00;
        full_instruction = 1'b0;
        full_data        = 1'b0;

        // ---- reset state, engine busy at startup ----------------------
        force_busy = 1'b1;
        rst        = 1'b1;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        bi = mon_ir.size(); bw = mon_work; bdn = mon_done; be = mon_err;
        send(8'h00);
        send(8'h15);
        cyc(20);
        check("startup_no_work_while_busy", 32'(mon_work - bw), 32'd0);
        check("startup_no_done_while_busy", 32'(mon_done - bdn), 32'd0);
        force_busy = 1'b0;
        wait_end(bdn, be, "startup");
        cyc(3);
        check("startup_work_count", 32'(mon_work - bw), 32'd1);
        check("startup_done_count", 32'(mon_done - bdn), 32'd1);
        check("startup_ir_writes", 32'(mon_ir.size() - bi), 32'd1);
        if (mon_ir.size() > bi) check("startup_ir_data", 32'(mon_ir[bi]), 32'h15);

        // ---- table-driven packets -------------------------------------
        for (int v = 0; v < NVEC; v++) begin
            bi = mon_ir.size(); bdr = mon_dr.size();
            bw = mon_work; bdn = mon_done; be = mon_err;
            send(vt[v].hdr);
            for (int k = 0; k < vt[v].npay; k++) send(vt[v].pay[k]);
            wait_end(bdn, be, vt[v].name);
            cyc(3);
            check({vt[v].name, "_done"}, 32'(mon_done - bdn), vt[v].exp_err ? 32'd0 : 32'd1);
            check({vt[v].name, "_err"}, 32'(mon_err - be), vt[v].exp_err ? 32'd1 : 32'd0);
            check({vt[v].name, "_work"}, 32'(mon_work - bw), vt[v].exp_err ? 32'd0 : 32'd1);
            if (vt[v].exp_err) begin
                check({vt[v].name, "_err_code"}, 32'(mon_code), 32'h1);
            end else begin
                check({vt[v].name, "_op_at_work"}, 32'(op_at_work), 32'(vt[v].exp_op));
                check({vt[v].name, "_op_at_done"}, 32'(op_at_done), 32'(vt[v].exp_op));
            end
            check({vt[v].name, "_n_ir"}, 32'(mon_ir.size() - bi), 32'(vt[v].exp_nir));
            check({vt[v].name, "_n_dr"}, 32'(mon_dr.size() - bdr), 32'(vt[v].exp_ndr));
            for (int k = 0; k < vt[v].exp_nir; k++)
                if (bi + k < mon_ir.size())
                    check({vt[v].name, "_ir_data"}, 32'(mon_ir[bi + k]), 32'(vt[v].exp_wr[k]));
            for (int k = 0; k < vt[v].exp_ndr; k++)
                if (bdr + k < mon_dr.size())
                    check({vt[v].name, "_dr_data"}, 32'(mon_dr[bdr + k]), 32'(vt[v].exp_wr[k]));
        end

        // ---- backpressure: data FIFO full for 10 cycles after byte 2 --
        bdr = mon_dr.size(); bdn = mon_done; be = mon_err;
        send(8'h40);
        send(8'hDE);
        full_data = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'hAD;
        low = 0;
        repeat (10) begin
            @(negedge clk);
            if (!s_ready) low++;
            @(posedge clk);
            #1;
        end
        check("bp_ready_low_cycles", 32'(low), 32'd10);
        check("bp_writes_during_stall", 32'(mon_dr.size() - bdr), 32'd1);
        full_data = 1'b0;
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        wait_end(bdn, be, "bp");
        cyc(3);
        check("bp_n_dr", 32'(mon_dr.size() - bdr), 32'd4);
        nw = mon_dr.size() - bdr;
        if (nw > 0) check("bp_dr0", 32'(mon_dr[bdr]), 32'hDE);
        if (nw > 1) check("bp_dr1", 32'(mon_dr[bdr + 1]), 32'hAD);
        if (nw > 2) check("bp_dr2", 32'(mon_dr[bdr + 2]), 32'hBE);
        if (nw > 3) check("bp_dr3", 32'(mon_dr[bdr + 3]), 32'hEF);
        check("bp_done", 32'(mon_done - bdn), 32'd1);

        // ---- reset in the middle of a DR packet -----------------------
        bi = mon_ir.size(); bdr = mon_dr.size(); bw = mon_work; bdn = mon_done; be = mon_err;
        send(8'h40);
        send(8'h11);
        rst = 1'b1;
        cyc(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        send(8'h00);
        send(8'h22);
        wait_end(bdn, be, "midrst");
        cyc(3);
        check("midrst_n_dr", 32'(mon_dr.size() - bdr), 32'd1);
        check("midrst_n_ir", 32'(mon_ir.size() - bi), 32'd1);
        if (mon_ir.size() > bi) check("midrst_ir_data", 32'(mon_ir[bi]), 32'h22);
        check("midrst_work", 32'(mon_work - bw), 32'd1);
        check("midrst_done", 32'(mon_done - bdn), 32'd1);

        // ---- engine never raises busy ---------------------------------
        never_rise = 1'b1;
        bw = mon_work; bdn = mon_done; be = mon_err;
        send(8'h00);
        send(8'h33);
`ifdef JTAG_CMD_SEQ_TIMEOUT_EN
        wait_end(bdn, be, "timeout");
        cyc(3);
        check("timeout_err", 32'(mon_err - be), 32'd1);
        check("timeout_err_code", 32'(mon_code), 32'h2);
        check("timeout_no_done", 32'(mon_done - bdn), 32'd0);
        check("timeout_work", 32'(mon_work - bw), 32'd1);
        // 100 cycles in ST_WAIT_BUSY after the kick cycle; err is registered
        // and so appears on the following cycle.
        check("timeout_latency", 32'(err_cyc - work_cyc), 32'd101);
        never_rise = 1'b0;
`else
        cyc(150);
        check("nowdog_no_err", 32'(mon_err - be), 32'd0);
        check("nowdog_no_done", 32'(mon_done - bdn), 32'd0);
        check("nowdog_work", 32'(mon_work - bw), 32'd1);
        s_valid = 1'b1;
        s_data  = 8'h00;
        @(negedge clk);
        check("nowdog_byte_stalled", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        never_rise = 1'b0;
        rst        = 1'b1;
        cyc(2);
        rst = 1'b0;
`endif
        bi = mon_ir.size(); bdn = mon_done; be = mon_err;
        send(8'h00);
        send(8'h34);
        wait_end(bdn, be, "after_stuck");
        cyc(3);
        check("after_stuck_done", 32'(mon_done - bdn), 32'd1);
        if (mon_ir.size() > bi) check("after_stuck_ir", 32'(mon_ir[mon_ir.size() - 1]), 32'h34);
        else bound_expired("after_stuck_ir");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
